// File: rtl/median_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | median_pkg: shared constants for the 3x3 window generator        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package median_pkg;

    localparam int PIX_W_DEFAULT = 8;

    // Window element index k = 3*row + col, row 0 on top, col 0 on the left
    localparam int WIN_TL = 0;
    localparam int WIN_TM = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_C  = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BM = 7;
    localparam int WIN_BR = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/window_3x3_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | window_3x3_gen_if: pixel-in / window-out handshake bundle        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface window_3x3_gen_if #(
    parameter int PIX_W = median_pkg::PIX_W_DEFAULT
);
    logic [PIX_W-1:0]   pix_in;
    logic               pix_in_valid;
    logic               pix_in_ready;
    logic [9*PIX_W-1:0] win_out;
    logic               win_valid;
    logic               win_ready;

    modport master (
        output pix_in, pix_in_valid, win_ready,
        input  pix_in_ready, win_out, win_valid
    );

    modport slave (
        input  pix_in, pix_in_valid, win_ready,
        output pix_in_ready, win_out, win_valid
    );
endinterface
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_buf: one-row pixel store, 1 write + 1 registered read port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module line_buf #(
    parameter int PIX_W  = median_pkg::PIX_W_DEFAULT,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);
    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | window_3x3_gen: raster 3x3 neighbourhood generator, edge padding |
// | Optional macro WIN_PAD_PORT_EN adds pad_val port.   Rev 1.0      |
// +------------------------------------------------------------------+
module window_3x3_gen
    import median_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEFAULT,
    parameter int MAX_WID = 512,
    parameter int WID_W   = 9,
    parameter int LEN_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WID_W-1:0] wid,
    input  logic [LEN_W-1:0] len,
`ifdef WIN_PAD_PORT_EN
    input  logic [PIX_W-1:0] pad_val,
`endif
    output logic             busy,
    output logic             done,
    window_3x3_gen_if.slave  bus
);
    localparam int IDX_W = WID_W + LEN_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [WID_W-1:0] WID_ONE = WID_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [2:0]             r_state;
    logic [WID_W-1:0]       r_wid;
    logic [LEN_W-1:0]       r_len;
    logic [IDX_W-1:0]       r_total;
    logic [IDX_W-1:0]       r_in_cnt;
    logic [IDX_W-1:0]       r_out_cnt;
    logic [WID_W-1:0]       r_x_in;
    logic [WID_W-1:0]       r_x_out;
    logic [LEN_W-1:0]       r_y_out;
    logic                   r_done;
    logic                   r_win_valid;
    logic [9*PIX_W-1:0]     r_win;
    // Last two stream columns per row; [1] is the newer one
    logic [2:0][1:0][PIX_W-1:0] r_sr;
    logic [PIX_W-1:0]       w_pad;

    logic                   w_slot_free;
    logic                   w_in_fire;
    logic                   w_adv;
    logic                   w_emit;
    logic                   w_bad_start;
    logic [PIX_W-1:0]       w_new_pix;
    logic [WID_W-1:0]       w_x_in_nxt;
    logic [PIX_W-1:0]       w_lb1_rd;
    logic [PIX_W-1:0]       w_lb2_rd;
    logic [8:0][PIX_W-1:0]  w_raw;
    logic [8:0][PIX_W-1:0]  w_win;
    logic                   w_pad_l, w_pad_r, w_pad_t, w_pad_b;

`ifdef WIN_PAD_PORT_EN
    logic [PIX_W-1:0] r_pad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pad <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_pad <= pad_val;
        end
    end
    assign w_pad = r_pad;
`else
    assign w_pad = '0;
`endif

    assign w_slot_free      = !r_win_valid || bus.win_ready;
    assign bus.pix_in_ready = (r_state == ST_PRIME) || (r_state == ST_RUN && w_slot_free);
    assign w_in_fire        = bus.pix_in_ready && bus.pix_in_valid;
    // Drain advances the stream with virtual zero pixels until every window exists
    assign w_adv  = w_in_fire ||
                    (r_state == ST_DRAIN && w_slot_free && r_out_cnt != r_total);
    assign w_emit = w_adv && (r_state != ST_PRIME);
    assign w_new_pix   = (r_state == ST_DRAIN) ? '0 : bus.pix_in;
    assign w_bad_start = (int'(wid) < 2) || (int'(len) < 2) || (int'(wid) > MAX_WID);

    // Read address runs one step ahead so registered read data lines up with the next accept
    always_comb begin
        w_x_in_nxt = r_x_in;
        if (r_state == ST_IDLE) begin
            w_x_in_nxt = '0;
        end else if (w_adv) begin
            w_x_in_nxt = (r_x_in == r_wid - WID_ONE) ? '0 : r_x_in + WID_ONE;
        end
    end

    line_buf #(.PIX_W(PIX_W), .DEPTH(MAX_WID), .ADDR_W(WID_W)) u_lb_row1 (
        .clk   (clk),
        .we    (w_adv),
        .waddr (r_x_in),
        .wdata (w_new_pix),
        .raddr (w_x_in_nxt),
        .rdata (w_lb1_rd)
    );

    line_buf #(.PIX_W(PIX_W), .DEPTH(MAX_WID), .ADDR_W(WID_W)) u_lb_row2 (
        .clk   (clk),
        .we    (w_adv),
        .waddr (r_x_in),
        .wdata (w_lb1_rd),
        .raddr (w_x_in_nxt),
        .rdata (w_lb2_rd)
    );

    always_comb begin
        w_raw         = '0;
        w_raw[WIN_TL] = r_sr[0][0];
        w_raw[WIN_TM] = r_sr[0][1];
        w_raw[WIN_TR] = w_lb2_rd;
        w_raw[WIN_ML] = r_sr[1][0];
        w_raw[WIN_C]  = r_sr[1][1];
        w_raw[WIN_MR] = w_lb1_rd;
        w_raw[WIN_BL] = r_sr[2][0];
        w_raw[WIN_BM] = r_sr[2][1];
        w_raw[WIN_BR] = w_new_pix;
    end

    // Edge padding comes from the output coordinates, never from buffer contents
    assign w_pad_l = (r_x_out == '0);
    assign w_pad_r = (r_x_out == r_wid - WID_ONE);
    assign w_pad_t = (r_y_out == '0);
    assign w_pad_b = (r_y_out == r_len - LEN_ONE);

    always_comb begin
        w_win = w_raw;
        for (int k = 0; k < 9; k++) begin
            if ((k % 3 == 0 && w_pad_l) || (k % 3 == 2 && w_pad_r) ||
                (k < 3 && w_pad_t) || (k >= 6 && w_pad_b)) begin
                w_win[k] = w_pad;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wid       <= '0;
            r_len       <= '0;
            r_total     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_x_in      <= '0;
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_done      <= 1'b0;
            r_win_valid <= 1'b0;
            r_win       <= '0;
            r_sr        <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_adv) begin
                r_sr[0]  <= {w_lb2_rd, r_sr[0][1]};
                r_sr[1]  <= {w_lb1_rd, r_sr[1][1]};
                r_sr[2]  <= {w_new_pix, r_sr[2][1]};
                r_x_in   <= w_x_in_nxt;
                r_in_cnt <= r_in_cnt + IDX_ONE;
            end

            if (w_emit) begin
                r_win       <= w_win;
                r_win_valid <= 1'b1;
                r_out_cnt   <= r_out_cnt + IDX_ONE;
                if (w_pad_r) begin
                    r_x_out <= '0;
                    r_y_out <= r_y_out + LEN_ONE;
                end else begin
                    r_x_out <= r_x_out + WID_ONE;
                end
            end else if (bus.win_ready) begin
                r_win_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_bad_start) begin
                            r_done <= 1'b1;
                        end else begin
                            r_wid     <= wid;
                            r_len     <= len;
                            r_total   <= IDX_W'(wid) * IDX_W'(len);
                            r_in_cnt  <= '0;
                            r_out_cnt <= '0;
                            r_x_in    <= '0;
                            r_x_out   <= '0;
                            r_y_out   <= '0;
                            r_state   <= ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    if (w_in_fire && r_in_cnt == IDX_W'(r_wid)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_in_fire && r_in_cnt == r_total - IDX_ONE) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_out_cnt == r_total && r_win_valid && bus.win_ready) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.win_out   = r_win;
    assign bus.win_valid = r_win_valid;
    assign busy = (r_state == ST_PRIME) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done = r_done;
endmodule
`default_nettype wire
